// File: rtl/booth_seq_mul.sv
// ---------------------------------------------------------------------------
// booth_seq_mul
//
// Sequential radix-2 Booth multiplier for signed two's-complement operands.
// One Booth step per iteration: an OP cycle adds/subtracts the multiplicand
// into the accumulator, then a SHIFT cycle arithmetic-shifts {A,Q,Q-1}.
// After W iterations the signed 2W-bit product is registered and held.
//
// Optional feature (compile-time define): BOOTH_SKIP_EN
//   When defined, an OP cycle whose Booth pair is 00 or 11 performs the
//   shift itself, so no-op iterations take one cycle instead of two.
//   The product is bit-identical in both builds.
//
// Parameters:
//   W             operand width (W >= 2)
// Ports:
//   clk           clock, rising edge
//   rst_b         asynchronous active-low reset
//   start         request a multiplication (sampled only while idle)
//   multiplicand  M operand, captured on the accepting edge
//   multiplier    Q operand, captured on the accepting edge
//   busy          high whenever the sequencer is not idle
//   done          one-cycle pulse, product valid in that cycle
//   product       signed 2W-bit result, held until the next completion
// ---------------------------------------------------------------------------
module booth_seq_mul #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [W-1:0]     multiplicand,
  input  logic [W-1:0]     multiplier,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   product
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE,
    OP,
    SHIFT,
    DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // A and M carry one extra sign bit so A-M cannot overflow even when the
  // multiplicand is the most negative W-bit value.
  logic [W:0]     r_a;
  logic [W:0]     r_m;
  logic [W-1:0]   r_q;
  logic           r_qm1;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_product;

  logic [W:0]     w_aOp;
  logic [W:0]     w_aShift;
  logic [W-1:0]   w_qShift;
  logic           w_qm1Shift;
  logic           w_last;
  logic           w_accept;
  logic           w_arith;
  logic           w_shiftEn;
`ifdef BOOTH_SKIP_EN
  logic           w_noop;
`endif

  // Booth step arithmetic and the arithmetic right shift of {A,Q,Q-1}.
  // The shift always works on the current register values: in the skip
  // build a no-op OP cycle leaves A unchanged, so shifting r_a is correct.
  always_comb begin
    w_aOp = r_a;
    case ({r_q[0], r_qm1})
      2'b10:   w_aOp = r_a - r_m;
      2'b01:   w_aOp = r_a + r_m;
      default: w_aOp = r_a;
    endcase
    w_aShift   = {r_a[W], r_a[W:1]};
    w_qShift   = {r_a[0], r_q[W-1:1]};
    w_qm1Shift = r_q[0];
    w_last     = (r_cnt == CW'(W - 1));
`ifdef BOOTH_SKIP_EN
    w_noop     = (r_q[0] == r_qm1);
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode plus the datapath enables for each state.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_arith     = 1'b0;
    w_shiftEn   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = OP;
        end
      end
      OP: begin
`ifdef BOOTH_SKIP_EN
        if (w_noop) begin
          w_shiftEn   = 1'b1;
          w_nextState = w_last ? DONE : OP;
        end else begin
          w_arith     = 1'b1;
          w_nextState = SHIFT;
        end
`else
        w_arith     = 1'b1;
        w_nextState = SHIFT;
`endif
      end
      SHIFT: begin
        w_shiftEn   = 1'b1;
        w_nextState = w_last ? DONE : OP;
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath registers. The product is loaded from the post-shift values
  // on the final shift, i.e. on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_a       <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_a   <= '0;
      r_q   <= multiplier;
      r_qm1 <= 1'b0;
      r_m   <= {multiplicand[W-1], multiplicand};
      r_cnt <= '0;
    end else if (w_arith) begin
      r_a <= w_aOp;
    end else if (w_shiftEn) begin
      r_a   <= w_aShift;
      r_q   <= w_qShift;
      r_qm1 <= w_qm1Shift;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_product <= {w_aShift[W-1:0], w_qShift};
      end
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign product = r_product;

endmodule

// File: tb/tb_booth_seq_mul.sv
// ---------------------------------------------------------------------------
// tb_booth_seq_mul
//
// Self-checking bench for booth_seq_mul. Three instances (W=8, W=4, W=16)
// are compared against a plain signed-multiplication reference. Latency is
// predicted from the Booth recoding of the multiplier (skip build) or fixed
// at 2W+1 (default build).
// ---------------------------------------------------------------------------
module tb_booth_seq_mul;

`ifdef BOOTH_SKIP_EN
  localparam bit SKIP_BUILD = 1'b1;
`else
  localparam bit SKIP_BUILD = 1'b0;
`endif

  logic clk;
  logic rstB;

  logic        start8;
  logic [7:0]  mcand8, mplier8;
  logic        busy8, done8;
  logic [15:0] product8;

  logic        start4;
  logic [3:0]  mcand4, mplier4;
  logic        busy4, done4;
  logic [7:0]  product4;

  logic        start16;
  logic [15:0] mcand16, mplier16;
  logic        busy16, done16;
  logic [31:0] product16;

  int checks;
  int errors;

  booth_seq_mul #(.W(8)) u8 (
    .clk(clk), .rst_b(rstB), .start(start8),
    .multiplicand(mcand8), .multiplier(mplier8),
    .busy(busy8), .done(done8), .product(product8)
  );

  booth_seq_mul #(.W(4)) u4 (
    .clk(clk), .rst_b(rstB), .start(start4),
    .multiplicand(mcand4), .multiplier(mplier4),
    .busy(busy4), .done(done4), .product(product4)
  );

  booth_seq_mul #(.W(16)) u16 (
    .clk(clk), .rst_b(rstB), .start(start16),
    .multiplicand(mcand16), .multiplier(mplier16),
    .busy(busy16), .done(done16), .product(product16)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed product of the low w bits of a and b, truncated to 2w bits.
  function automatic logic [31:0] expProd(input int w, input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, mask;
    sa = longint'(a);
    sb = longint'(b);
    if (a[w-1]) sa = sa - (longint'(1) << w);
    if (b[w-1]) sb = sb - (longint'(1) << w);
    mask = (longint'(1) << (2 * w)) - 1;
    return 32'((sa * sb) & mask);
  endfunction

  // Reference latency: 2w+1 by default; in the skip build w+k+1 where k is
  // the number of nonzero Booth digits (bit differs from the bit below it).
  function automatic int expLat(input int w, input logic [15:0] q);
    int   k;
    logic prev;
    k    = 0;
    prev = 1'b0;
    for (int i = 0; i < w; i++) begin
      if (q[i] != prev) k++;
      prev = q[i];
    end
    return SKIP_BUILD ? (w + k + 1) : (2 * w + 1);
  endfunction

  // One W=8 multiplication: accept, scramble operands, wait for done,
  // check product, latency and the single-cycle pulse.
  task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b);
    int          cyc;
    bit          got;
    logic [15:0] p;
    p = '0;
    @(negedge clk);
    mcand8  = a;
    mplier8 = b;
    start8  = 1'b1;
    @(negedge clk);
    start8  = 1'b0;
    mcand8  = 8'($urandom);
    mplier8 = 8'($urandom);
    checkOutput({tag, " busy"}, 32'(busy8), 32'd1);
    cyc = 1;
    got = 1'b0;
    while (!got && cyc < 100) begin
      if (done8) begin
        got = 1'b1;
        p   = product8;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput({tag, " done seen"}, 32'(got), 32'd1);
    checkOutput({tag, " product"}, 32'(p), expProd(8, 16'(a), 16'(b)));
    checkOutput({tag, " latency"}, 32'(cyc), 32'(expLat(8, 16'(b))));
    @(negedge clk);
    checkOutput({tag, " done pulse"}, 32'(done8), 32'd0);
    checkOutput({tag, " idle"}, 32'(busy8), 32'd0);
    checkOutput({tag, " product held"}, 32'(product8), expProd(8, 16'(a), 16'(b)));
  endtask

  // Concurrent random trials on the W=4 and W=16 instances.
  task automatic runSweep(input int trial);
    logic [3:0]  a4, b4;
    logic [15:0] a16, b16;
    int          cyc, c4, c16;
    bit          got4, got16;
    logic [7:0]  p4;
    logic [31:0] p16;
    a4  = 4'($urandom);
    b4  = 4'($urandom);
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    if (trial == 0) begin
      a4 = 4'h8; b4 = 4'h8; a16 = 16'h8000; b16 = 16'h8000;
    end else if (trial == 1) begin
      a4 = 4'h8; b4 = 4'h7; a16 = 16'h8000; b16 = 16'h7FFF;
    end
    c4 = 0; c16 = 0; p4 = '0; p16 = '0;
    got4 = 1'b0; got16 = 1'b0;
    @(negedge clk);
    mcand4 = a4; mplier4 = b4; start4 = 1'b1;
    mcand16 = a16; mplier16 = b16; start16 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; start16 = 1'b0;
    mcand4 = 4'($urandom); mcand16 = 16'($urandom);
    cyc = 1;
    while (!(got4 && got16) && cyc < 200) begin
      if (done4 && !got4) begin
        got4 = 1'b1; c4 = cyc; p4 = product4;
      end
      if (done16 && !got16) begin
        got16 = 1'b1; c16 = cyc; p16 = product16;
      end
      if (!(got4 && got16)) begin
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput("w4 done seen", 32'(got4), 32'd1);
    checkOutput("w16 done seen", 32'(got16), 32'd1);
    checkOutput("w4 product", 32'(p4), expProd(4, 16'(a4), 16'(b4)));
    checkOutput("w16 product", p16, expProd(16, a16, b16));
    checkOutput("w4 latency", 32'(c4), 32'(expLat(4, 16'(b4))));
    checkOutput("w16 latency", 32'(c16), 32'(expLat(16, b16)));
    @(negedge clk);
  endtask

  // Hold start high across two operations while scrambling operands: each
  // accept must use the operands present on its own accepting edge, and
  // start during DONE must not be taken.
  task automatic applyHeldStart();
    logic [7:0]  a0, b0, a1, b1;
    int          l0, l1, doneCount, d0, d1, w;
    logic [15:0] p0, p1;
    a0 = 8'h2D; b0 = 8'hB3; a1 = 8'h9C; b1 = 8'h01;
    l0 = expLat(8, 16'(b0));
    l1 = expLat(8, 16'(b1));
    doneCount = 0; d0 = 0; d1 = 0; p0 = '0; p1 = '0;
    @(negedge clk);
    mcand8 = a0; mplier8 = b0; start8 = 1'b1;
    for (int c = 1; c <= l0 + l1 + 3; c++) begin
      @(negedge clk);
      if (done8) begin
        doneCount++;
        if (doneCount == 1) begin d0 = c; p0 = product8; end
        if (doneCount == 2) begin d1 = c; p1 = product8; end
      end
      if (c == l0 + 1) begin
        mcand8 = a1; mplier8 = b1;
      end else begin
        mcand8 = 8'($urandom); mplier8 = 8'($urandom);
      end
    end
    start8 = 1'b0;
    checkOutput("held done count", 32'(doneCount), 32'd2);
    checkOutput("held first cycle", 32'(d0), 32'(l0));
    checkOutput("held first product", 32'(p0), expProd(8, 16'(a0), 16'(b0)));
    checkOutput("held second cycle", 32'(d1), 32'(l0 + 1 + l1));
    checkOutput("held second product", 32'(p1), expProd(8, 16'(a1), 16'(b1)));
    w = 0;
    while (busy8 && w < 100) begin
      @(negedge clk);
      w++;
    end
    checkOutput("held drain", 32'(busy8), 32'd0);
  endtask

  // Main sequence.
  initial begin
    checks = 0;
    errors = 0;
    rstB = 1'b1;
    start8 = 1'b0;  mcand8 = '0;  mplier8 = '0;
    start4 = 1'b0;  mcand4 = '0;  mplier4 = '0;
    start16 = 1'b0; mcand16 = '0; mplier16 = '0;
    #2 rstB = 1'b0;
    #1;
    checkOutput("reset busy", 32'(busy8), 32'd0);
    checkOutput("reset done", 32'(done8), 32'd0);
    checkOutput("reset product", 32'(product8), 32'd0);
    repeat (2) @(negedge clk);
    rstB = 1'b1;

    applyStimulus("7x-3", 8'h07, 8'hFD);
    applyStimulus("-128x127", 8'h80, 8'h7F);
    applyStimulus("-128x-128", 8'h80, 8'h80);
    applyStimulus("5x0", 8'h05, 8'h00);
    applyStimulus("3x55", 8'h03, 8'h55);
    applyStimulus("-1x-1", 8'hFF, 8'hFF);

    // Reset in cycle 5 of an operation clears everything immediately.
    @(negedge clk);
    mcand8 = 8'h11; mplier8 = 8'h22; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rstB = 1'b0;
    #1;
    checkOutput("midreset busy", 32'(busy8), 32'd0);
    checkOutput("midreset done", 32'(done8), 32'd0);
    checkOutput("midreset product", 32'(product8), 32'd0);
    @(negedge clk);
    rstB = 1'b1;
    applyStimulus("post reset", 8'h0D, 8'hF6);

    applyHeldStart();

    for (int i = 0; i < 20; i++) begin
      applyStimulus("rand8", 8'($urandom), 8'($urandom));
    end

    for (int i = 0; i < 200; i++) begin
      runSweep(i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a hung sequencer.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
